// File: rtl/proc_sequencer.sv
// proc_sequencer: multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK controller
// owning pc, ir and the imem port, plus host program load and
// run/step/halt control.
// Ports: clk, rst (async, active-high); run_req, step_req, halt_req;
//   host_load_valid/ready/addr/data; imem_addr/we/wdata/rdata;
//   jump, branch, alu_zero from control/ALU; pc, ir, ex_valid,
//   rf_we_en, halted, retired to the core.
// Optional: PROC_SEQ_HALT_INSTR_EN makes ir==8'hE0 a HALT instruction.
module proc_sequencer #(
    parameter logic [7:0] PC_RESET = 8'h00,
    parameter int         RETIRE_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run_req,
    input  logic                step_req,
    input  logic                halt_req,
    input  logic                host_load_valid,
    output logic                host_load_ready,
    input  logic [7:0]          host_load_addr,
    input  logic [7:0]          host_load_data,
    output logic [7:0]          imem_addr,
    output logic                imem_we,
    output logic [7:0]          imem_wdata,
    input  logic [7:0]          imem_rdata,
    input  logic                jump,
    input  logic                branch,
    input  logic                alu_zero,
    output logic [7:0]          pc,
    output logic [7:0]          ir,
    output logic                ex_valid,
    output logic                rf_we_en,
    output logic                halted,
    output logic [RETIRE_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          pc_q, pc_d;
    logic [7:0]          ir_q, ir_d;
    logic [RETIRE_W-1:0] ret_q, ret_d;
    logic                taken_q, taken_d;
    logic                step_q, step_d;
    logic [7:0]          ladr_q, ladr_d;
    logic [7:0]          ldat_q, ldat_d;
    logic                is_halt;

`ifdef PROC_SEQ_HALT_INSTR_EN
    // ir is stable from DECODE through WRITEBACK, so decoding it
    // in WRITEBACK is equivalent to flagging it in EXECUTE.
    assign is_halt = (ir_q == 8'hE0);
`else
    assign is_halt = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= PC_RESET;
            ir_q    <= 8'h00;
            ret_q   <= '0;
            taken_q <= 1'b0;
            step_q  <= 1'b0;
            ladr_q  <= 8'h00;
            ldat_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            ret_q   <= ret_d;
            taken_q <= taken_d;
            step_q  <= step_d;
            ladr_q  <= ladr_d;
            ldat_q  <= ldat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        ret_d   = ret_q;
        taken_d = taken_q;
        step_d  = step_q;
        ladr_d  = ladr_q;
        ldat_d  = ldat_q;
        unique case (state_q)
            S_IDLE: begin
                if (host_load_valid) begin
                    state_d = S_LOAD;
                    ladr_d  = host_load_addr;
                    ldat_d  = host_load_data;
                end else if (run_req && !halt_req) begin
                    state_d = S_FETCH;
                    step_d  = 1'b0;
                end else if (step_req) begin
                    state_d = S_FETCH;
                    step_d  = 1'b1;
                end
            end
            S_LOAD:   state_d = S_IDLE;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                ir_d    = imem_rdata;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                taken_d = jump | (branch & alu_zero);
                state_d = S_WB;
            end
            S_WB: begin
                if (taken_q && !is_halt)
                    pc_d = {3'b000, ir_q[4:0]};
                else
                    pc_d = pc_q + 8'd1;
                ret_d = ret_q + RETIRE_W'(1);
                if (run_req && !halt_req && !step_q && !is_halt)
                    state_d = S_FETCH;
                else
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign host_load_ready = (state_q == S_IDLE);
    assign halted          = (state_q == S_IDLE);
    assign imem_we         = (state_q == S_LOAD);
    assign imem_wdata      = ldat_q;
    assign imem_addr       = (state_q == S_LOAD) ? ladr_q : pc_q;
    assign ex_valid        = (state_q == S_EXEC);
    assign rf_we_en        = (state_q == S_WB) && !is_halt;
    assign pc              = pc_q;
    assign ir              = ir_q;
    assign retired         = ret_q;

endmodule

// File: doc/proc_sequencer.md
# proc_sequencer

Multi-cycle controller that sequences the 8-bit processor datapath: instruction fetch, decode, execute and writeback. It owns the PC, instruction register and instruction-memory port. It also gives a host side-channel for loading programs and run/step/halt control. The block sits between the host/debug logic and the core's control unit, ALU, register file and instruction memory.

## Interface
- PC_RESET, 8'h00, PC value loaded on reset.
- RETIRE_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- run_req  in  1  level request for continuous execution.
- step_req  in  1  one-cycle pulse requesting one instruction, sampled in IDLE only.
- halt_req  in  1  level request to stop at the next instruction boundary.
- host_load_valid  in  1  host imem write request.
- host_load_ready  out  1  host write accepted when high with valid.
- host_load_addr  in  8  imem write address.
- host_load_data  in  8  imem write data.
- imem_addr  out  8  imem address; equals pc except during LOAD.
- imem_we  out  1  imem write strobe.
- imem_wdata  out  8  imem write data.
- imem_rdata  in  8  imem synchronous read data, 1-cycle latency.
- jump  in  1  control-unit jump decode of ir.
- branch  in  1  control-unit branch decode of ir.
- alu_zero  in  1  ALU zero flag.
- pc  out  8  program counter.
- ir  out  8  instruction register, which drives opcode, register address and immediate decode.
- ex_valid  out  1  high in EXECUTE.
- rf_we_en  out  1  high in WRITEBACK; the core ANDs this with reg_write.
- halted  out  1  high in IDLE.
- retired  out  RETIRE_W  count of completed instructions.

## Operation
- States: IDLE, LOAD, FETCH, DECODE, EXECUTE, WRITEBACK.
- IDLE: host_load_ready=1. Priority order is load, then run, then step:
  - host_load_valid → LOAD, with addr/data registered.
  - else run_req && !halt_req → FETCH, with step_mode=0.
  - else step_req → FETCH, with step_mode=1.
- LOAD: imem_we=1 for exactly one cycle with the registered addr/data, then → IDLE. host_load_ready=0 in every non-IDLE state.
- FETCH: imem_addr=pc, then → DECODE.
- DECODE: ir ← imem_rdata at the end of the cycle, then → EXECUTE.
- EXECUTE: ex_valid=1. At the end of the cycle, taken ← jump | (branch & alu_zero). Then → WRITEBACK.
- WRITEBACK: rf_we_en=1.
  - pc ← taken ? {3'b000, ir[4:0]} : pc+1. pc+1 wraps 8'hFF→8'h00.
  - retired ← retired+1, wrapping at 2^RETIRE_W.
  - Next state is FETCH if run_req && !halt_req && !step_mode; otherwise IDLE.
- halt_req is honoured only at a WRITEBACK boundary. It never aborts an instruction in flight.
- A step_req or host_load_valid arriving in a non-IDLE state is ignored; there is no queuing.
- Reset mid-instruction aborts immediately. No writeback completes, and pc is not updated.

## Timing
- Reset values:
  - state IDLE, pc=PC_RESET, ir=8'h00, retired=0, taken=0, step_mode=0.
  - imem_we=0, ex_valid=0, rf_we_en=0.
  - halted=1, host_load_ready=1.
- Each instruction takes exactly 4 cycles: FETCH, DECODE, EXECUTE, WRITEBACK.
- The first FETCH occurs the cycle after run_req is sampled high in IDLE.
- A host load occupies 2 cycles: accept in IDLE, write in LOAD. Back-to-back loads are accepted every 2 cycles.
- All outputs are registered-state decodes. Nothing combinational passes from input to output, except imem_addr muxing on state.
- The new pc is visible the cycle after WRITEBACK, which is the next FETCH.

## Configuration
- Macro: PROC_SEQ_HALT_INSTR_EN.
- Defined: an ir of 8'hE0 in EXECUTE is treated as HALT.
  - WRITEBACK still occurs, but rf_we_en=0.
  - pc ← pc+1 and retired increments.
  - Next state is forced to IDLE regardless of run_req.
- Undefined: 8'hE0 is an ordinary instruction, decoded by the control unit like any other.

## Test plan
- Reset, then load 0x0D,0x12,0x46,0xC0 at addresses 0–3 → imem_we pulses once per load, 2 cycles apart; host_load_ready=0 in each LOAD cycle.
- run_req=1 from pc=0 → FETCH/DECODE/EXECUTE/WRITEBACK repeat every 4 cycles; retired=3 after 12 cycles; ir=0x46 in the third EXECUTE.
- Jump at pc=3 with ir=0xC0 and jump=1 → pc=0x00 after WRITEBACK. A branch with alu_zero=0 → pc=4.
- step_req pulse in IDLE → exactly one instruction, retired increments by 1, halted=1 again 5 cycles after the pulse; run_req=0 throughout.
- halt_req asserted during DECODE of an instruction at pc=5 → that instruction completes, pc=6, state IDLE; no FETCH follows.
- rst asserted in EXECUTE → state IDLE, pc=PC_RESET, retired=0 immediately, with no rf_we_en pulse. With PROC_SEQ_HALT_INSTR_EN defined, 0xE0 at pc=2 under run_req → IDLE with pc=3 and rf_we_en held 0.
